mem_access_unit: RTL

Parametrised memory access unit replacing the fixed MAR/MDR/SRAM-gate datapath slice of the 16-bit processor. It latches an address and write data from the CPU bus on request, runs a multi-cycle asynchronous-SRAM read or write with a configurable number of wait states, drives the shared bidirectional data pins, and returns read data through its MDR. It sits between the ISDU-controlled bus and the external SRAM pins.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// master = CPU bus / ISDU side, slave = the access unit.
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              Req;
  logic              We;
  logic [ADDR_W-1:0] Addr_in;
  logic [DATA_W-1:0] Wdata;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Rdata;

  modport master (
    output Req, We, Addr_in, Wdata,
    input  Busy, Done, Rdata
  );

  modport slave (
    input  Req, We, Addr_in, Wdata,
    output Busy, Done, Rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR memory access unit driving async SRAM with WAIT_STATES strobe cycles.
// Optional MEM_BYTE_LANE_EN adds Byte_en lane selection on the SRAM side.
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  mem_access_unit_if.slave    bus,
`ifdef MEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0] Byte_en,
`endif
  output logic [ADDR_W-1:0]   ADDR,
  inout  wire  [DATA_W-1:0]   Data,
  output logic                Mem_CE_n,
  output logic                Mem_OE_n,
  output logic                Mem_WE_n,
  output logic [DATA_W/8-1:0] Mem_BE_n
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rmask;
  logic              drive;

`ifdef MEM_BYTE_LANE_EN
  logic [NB-1:0]     be_q, be_d;

  always_comb begin
    rmask = '0;
    for (int i = 0; i < NB; i++)
      rmask[8*i +: 8] = {8{be_q[i]}};
  end

  assign Mem_BE_n = Mem_CE_n ? '1 : ~be_q;
`else
  assign rmask    = '1;
  assign Mem_BE_n = Mem_CE_n ? '1 : '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef MEM_BYTE_LANE_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
`ifdef MEM_BYTE_LANE_EN
      be_q    <= be_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
`ifdef MEM_BYTE_LANE_EN
    be_d     = be_q;
`endif
    Mem_CE_n = 1'b1;
    Mem_OE_n = 1'b1;
    Mem_WE_n = 1'b1;
    drive    = 1'b0;
    bus.Busy = 1'b1;
    bus.Done = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.Busy = 1'b0;
        if (bus.Req) begin
          mar_d   = bus.Addr_in;
          we_d    = bus.We;
          cnt_d   = CW'(WAIT_STATES - 1);
          if (bus.We)
            mdr_d = bus.Wdata;
`ifdef MEM_BYTE_LANE_EN
          be_d    = Byte_en;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        Mem_CE_n = 1'b0;
        drive    = we_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        Mem_CE_n = 1'b0;
        Mem_OE_n = we_q;
        Mem_WE_n = !we_q;
        drive    = we_q;
        if (cnt_q == '0) begin
          if (!we_q)
            mdr_d = Data & rmask;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        // data stays on the pins one more cycle for SRAM hold time
        Mem_CE_n = 1'b0;
        drive    = we_q;
        bus.Done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Data      = drive ? mdr_q : {DATA_W{1'bz}};
  assign ADDR      = mar_q;
  assign bus.Rdata = mdr_q;

endmodule
